// File: rtl/uart_avmm_sequencer.sv
// Avalon-MM master for the UART CSR slave: programs BAUD_GEN/CONTROL, then polls
// status and moves bytes between the TX/RX streams and the UART FIFOs.
//
// state    | meaning
// UNCFG    | idle after reset, waits for cfg_start
// CFG_BAUD | writing BAUD_GEN
// CFG_CTRL | writing CONTROL
// POLL     | reading STATUS and choosing the next access
// GAP      | idle back-off after a poll that found no work
// TX_WR    | writing the held TX byte into the TX FIFO
// RX_RD    | reading one word from the RX FIFO
module uart_avmm_sequencer #(
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_pbit,
    input  logic        cfg_ptype,
    input  logic [1:0]  cfg_sbit,
    input  logic [11:0] cfg_baud_freq,
    input  logic [15:0] cfg_baud_limit,
    input  logic        cfg_start,
    output logic        cfg_done,
    input  logic [7:0]  s_tx_data,
    input  logic        s_tx_valid,
    output logic        s_tx_ready,
    output logic [7:0]  m_rx_data,
    output logic        m_rx_err,
    output logic        m_rx_valid,
    input  logic        m_rx_ready,
    output logic [2:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam int GW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

    typedef enum logic [2:0] {
        UNCFG, CFG_BAUD, CFG_CTRL, POLL, GAP, TX_WR, RX_RD
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   gap_cnt;
    logic            cfg_pending;
    logic            last_served;
    logic            tx_hold_valid;
    logic [7:0]      tx_hold;

    logic            busy, accept, reconf, launch, to_baud;
    logic            tx_ok, rx_ok;
    logic [2:0]      l_address;
    logic            l_read, l_write;
    logic [31:0]     l_writedata;
    logic [3:0]      l_byteenable;
    logic            unused_rdata;

    assign busy         = avm_read | avm_write;
    assign accept       = busy & ~avm_waitrequest;
    assign reconf       = cfg_pending | cfg_start;
    assign s_tx_ready   = ~tx_hold_valid;
    assign unused_rdata = ^{avm_readdata[31:9], avm_readdata[2:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= UNCFG;
        else          state <= state_nxt;
    end

    // Status bits are decided on directly in the acceptance cycle of the poll.
    always_comb begin
        state_nxt = state;
        tx_ok     = tx_hold_valid & ~avm_readdata[3];
        rx_ok     = ~avm_readdata[0] & ~m_rx_valid;
        case (state)
            UNCFG:    if (cfg_start) state_nxt = CFG_BAUD;
            CFG_BAUD: if (accept) state_nxt = reconf ? CFG_BAUD : CFG_CTRL;
            CFG_CTRL: if (accept) state_nxt = reconf ? CFG_BAUD : POLL;
            POLL: begin
                if (accept) begin
                    if (reconf)                 state_nxt = CFG_BAUD;
                    else if (tx_ok && rx_ok)    state_nxt = last_served ? RX_RD : TX_WR;
                    else if (tx_ok)             state_nxt = TX_WR;
                    else if (rx_ok)             state_nxt = RX_RD;
                    else if (POLL_GAP == 0)     state_nxt = POLL;
                    else                        state_nxt = GAP;
                end
            end
            GAP: begin
                if (reconf)            state_nxt = CFG_BAUD;
                else if (gap_cnt == 0) state_nxt = POLL;
            end
            TX_WR:    if (accept) state_nxt = POLL;
            RX_RD:    if (accept) state_nxt = POLL;
            default:  state_nxt = UNCFG;
        endcase
    end

    assign to_baud = (state_nxt == CFG_BAUD) && ((state != CFG_BAUD) || accept);

    always_comb begin
        l_address    = 3'd0;
        l_read       = 1'b0;
        l_write      = 1'b0;
        l_writedata  = 32'h0;
        l_byteenable = 4'h0;
        launch       = 1'b0;
        case (state)
            CFG_BAUD: begin
                launch       = ~busy;
                l_address    = 3'd1;
                l_write      = 1'b1;
                l_writedata  = {4'h0, cfg_baud_freq, cfg_baud_limit};
                l_byteenable = 4'hF;
            end
            CFG_CTRL: begin
                launch       = ~busy;
                l_address    = 3'd0;
                l_write      = 1'b1;
                l_writedata  = {20'h0, cfg_sbit, cfg_ptype, cfg_pbit, 8'h0};
                l_byteenable = 4'b0010;
            end
            POLL: begin
                launch       = ~busy;
                l_address    = 3'd0;
                l_read       = 1'b1;
                l_byteenable = 4'hF;
            end
            TX_WR: begin
                launch       = ~busy;
                l_address    = 3'd4;
                l_write      = 1'b1;
                l_writedata  = {24'h0, tx_hold};
                l_byteenable = 4'b0001;
            end
            RX_RD: begin
                launch       = ~busy;
                l_address    = 3'd5;
                l_read       = 1'b1;
                l_byteenable = 4'hF;
            end
            default: launch = 1'b0;
        endcase
    end

    // Address/data stay at their last value after a strobe drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address    <= 3'd0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0;
            avm_byteenable <= 4'h0;
        end else if (launch) begin
            avm_address    <= l_address;
            avm_read       <= l_read;
            avm_write      <= l_write;
            avm_writedata  <= l_writedata;
            avm_byteenable <= l_byteenable;
        end else if (accept) begin
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (state == POLL && state_nxt == GAP) begin
            gap_cnt <= GAP_LOAD;
        end else if (state == GAP && gap_cnt != 0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_pending <= 1'b0;
            cfg_done    <= 1'b0;
        end else begin
            if (to_baud)
                cfg_pending <= 1'b0;
            else if (cfg_start && state != UNCFG)
                cfg_pending <= 1'b1;

            if (cfg_start)
                cfg_done <= 1'b0;
            else if (state == CFG_CTRL && accept && !reconf)
                cfg_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold_valid <= 1'b0;
            tx_hold       <= 8'h0;
        end else if (s_tx_valid && !tx_hold_valid) begin
            tx_hold_valid <= 1'b1;
            tx_hold       <= s_tx_data;
        end else if (state == TX_WR && accept) begin
            tx_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rx_valid  <= 1'b0;
            m_rx_data   <= 8'h0;
            m_rx_err    <= 1'b0;
            last_served <= 1'b0;
        end else begin
            if (state == RX_RD && accept) begin
                m_rx_valid  <= 1'b1;
                m_rx_data   <= avm_readdata[7:0];
                m_rx_err    <= avm_readdata[8];
                last_served <= 1'b0;
            end else if (m_rx_valid && m_rx_ready) begin
                m_rx_valid  <= 1'b0;
            end
            if (state == TX_WR && accept)
                last_served <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_avmm_sequencer.sv
// Directed bench for uart_avmm_sequencer: a stalling CSR slave model logs every
// accepted access, and a linear stimulus sequence checks the log and stream outputs.
module tb_uart_avmm_sequencer;
    localparam int POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_pbit = 1'b0, cfg_ptype = 1'b0, cfg_start = 1'b0;
    logic [1:0]  cfg_sbit = 2'b00;
    logic [11:0] cfg_baud_freq = 12'h0;
    logic [15:0] cfg_baud_limit = 16'h0;
    logic        cfg_done;
    logic [7:0]  s_tx_data = 8'h0;
    logic        s_tx_valid = 1'b0, s_tx_ready;
    logic [7:0]  m_rx_data;
    logic        m_rx_err, m_rx_valid;
    logic        m_rx_ready = 1'b0;
    logic [2:0]  avm_address;
    logic        avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    uart_avmm_sequencer #(.POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_pbit(cfg_pbit), .cfg_ptype(cfg_ptype), .cfg_sbit(cfg_sbit),
        .cfg_baud_freq(cfg_baud_freq), .cfg_baud_limit(cfg_baud_limit),
        .cfg_start(cfg_start), .cfg_done(cfg_done),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_err(m_rx_err), .m_rx_valid(m_rx_valid),
        .m_rx_ready(m_rx_ready),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int stall_cfg = 0, stall_left = 0;
    logic [31:0] status = 32'h9;
    logic [31:0] rx_word = 32'h0;
    int cyc = 0, log_n = 0, viol = 0;
    logic [2:0]  log_addr [64];
    logic        log_wr   [64];
    logic [31:0] log_data [64];
    logic [3:0]  log_be   [64];
    int          log_cyc  [64];
    logic        prev_st = 1'b0;
    logic [40:0] prev_bus = '0;
    logic        bus_busy;
    logic [40:0] cur_bus;

    assign bus_busy = avm_read | avm_write;
    assign cur_bus  = {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};

    always_comb begin
        avm_waitrequest = bus_busy && (stall_left != 0);
        avm_readdata    = 32'h0;
        if (avm_read && avm_address == 3'd0) avm_readdata = status;
        if (avm_read && avm_address == 3'd5) avm_readdata = rx_word;
    end

    // Slave model: stalls each access stall_cfg cycles, logs acceptances, flags protocol breaks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            prev_st    <= 1'b0;
            stall_left <= stall_cfg;
        end else begin
            viol <= viol + int'(prev_st && (cur_bus !== prev_bus)) + int'(avm_read && avm_write);
            if (bus_busy && !avm_waitrequest) begin
                if (log_n < 64) begin
                    log_addr[log_n] <= avm_address;
                    log_wr[log_n]   <= avm_write;
                    log_data[log_n] <= avm_writedata;
                    log_be[log_n]   <= avm_byteenable;
                    log_cyc[log_n]  <= cyc;
                end
                log_n <= log_n + 1;
            end
            if (!bus_busy)            stall_left <= stall_cfg;
            else if (stall_left != 0) stall_left <= stall_left - 1;
            prev_st  <= bus_busy && avm_waitrequest;
            prev_bus <= cur_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int n, input string tag);
        int t = 0;
        while (log_n < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        nvec++;
        assert (log_n >= n) else begin
            nerr++;
            $error("FAIL %s: timeout, accepted %0d expected %0d", tag, log_n, n);
        end
    endtask

    task automatic wait_bus(input logic wr, input logic [2:0] addr, input string tag);
        int t = 0;
        while (!((wr ? avm_write : avm_read) && avm_address == addr) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, {31'h0, (wr ? avm_write : avm_read)}, 32'h1);
    endtask

    task automatic chk_entry(input int i, input string tag, input logic [2:0] addr,
                             input logic wr, input logic [31:0] data, input logic [3:0] be);
        chk({tag, "_addr"}, {29'h0, log_addr[i]}, {29'h0, addr});
        chk({tag, "_wr"}, {31'h0, log_wr[i]}, {31'h0, wr});
        if (wr) begin
            chk({tag, "_data"}, log_data[i], data);
            chk({tag, "_be"}, {28'h0, log_be[i]}, {28'h0, be});
        end
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("rst_read", {31'h0, avm_read}, 32'h0);
        chk("rst_write", {31'h0, avm_write}, 32'h0);
        chk("rst_addr", {29'h0, avm_address}, 32'h0);
        chk("rst_wdata", avm_writedata, 32'h0);
        chk("rst_be", {28'h0, avm_byteenable}, 32'h0);
        chk("rst_cfg_done", {31'h0, cfg_done}, 32'h0);
        chk("rst_rx_valid", {31'h0, m_rx_valid}, 32'h0);
        chk("rst_rx_data", {24'h0, m_rx_data}, 32'h0);
        chk("rst_tx_ready", {31'h0, s_tx_ready}, 32'h1);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("uncfg_no_bus", log_n, 0);

        // Configuration sequence
        cfg_baud_freq = 12'h123; cfg_baud_limit = 16'h0456;
        cfg_pbit = 1'b1; cfg_ptype = 1'b1; cfg_sbit = 2'b10;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_log(1, "cfg_baud_wait");
        chk("cfg_done_early", {31'h0, cfg_done}, 32'h0);
        wait_log(3, "cfg_poll_wait");
        chk_entry(0, "cfg_baud", 3'd1, 1'b1, 32'h01230456, 4'hF);
        chk_entry(1, "cfg_ctrl", 3'd0, 1'b1, 32'h00000B00, 4'h2);
        chk_entry(2, "first_poll", 3'd0, 1'b0, 32'h0, 4'h0);
        chk("cfg_done_set", {31'h0, cfg_done}, 32'h1);
        wait_log(5, "gap_wait");
        chk("poll_spacing_nowait", log_cyc[4] - log_cyc[3], 6);

        // TX byte held while tx_full, every access stalled 5 cycles
        stall_cfg = 5;
        s_tx_data = 8'hA5; s_tx_valid = 1'b1;
        @(negedge clk);
        s_tx_valid = 1'b0;
        chk("tx_ready_low", {31'h0, s_tx_ready}, 32'h0);
        n0 = log_n;
        wait_log(n0 + 3, "stall_polls");
        for (int i = 0; i < 3; i++) chk_entry(n0 + i, "full_poll", 3'd0, 1'b0, 32'h0, 4'h0);
        chk("poll_spacing_stall", log_cyc[n0 + 2] - log_cyc[n0 + 1], 11);
        chk("tx_ready_held", {31'h0, s_tx_ready}, 32'h0);

        // TX path once tx_full clears
        stall_cfg = 0;
        status = 32'h1;
        n0 = log_n;
        wait_log(n0 + 1, "tx_poll");
        chk("tx_ready_pre_wr", {31'h0, s_tx_ready}, 32'h0);
        wait_log(n0 + 2, "tx_write");
        chk_entry(n0, "tx_poll", 3'd0, 1'b0, 32'h0, 4'h0);
        chk_entry(n0 + 1, "tx_wr", 3'd4, 1'b1, 32'h000000A5, 4'h1);
        chk("tx_ready_post_wr", {31'h0, s_tx_ready}, 32'h1);

        // RX path with the consumer stalled
        status = 32'h0; rx_word = 32'h000001C3; m_rx_ready = 1'b0;
        n0 = log_n;
        wait_log(n0 + 2, "rx_read");
        chk_entry(n0 + 1, "rx_rd", 3'd5, 1'b0, 32'h0, 4'h0);
        chk("rx_valid", {31'h0, m_rx_valid}, 32'h1);
        chk("rx_data", {24'h0, m_rx_data}, 32'hC3);
        chk("rx_err", {31'h0, m_rx_err}, 32'h1);
        wait_log(n0 + 5, "rx_blocked");
        for (int i = 2; i < 5; i++) chk_entry(n0 + i, "rx_blocked", 3'd0, 1'b0, 32'h0, 4'h0);
        m_rx_ready = 1'b1;
        @(negedge clk);
        m_rx_ready = 1'b0;
        chk("rx_valid_clear", {31'h0, m_rx_valid}, 32'h0);

        // Reset in the middle of a stalled poll with a TX byte held
        status = 32'h9; stall_cfg = 5;
        s_tx_data = 8'h77; s_tx_valid = 1'b1;
        @(negedge clk);
        s_tx_valid = 1'b0;
        wait_bus(1'b0, 3'd0, "stalled_poll_seen");
        reset_n = 1'b0;
        #1;
        chk("async_rst_read", {31'h0, avm_read}, 32'h0);
        chk("async_rst_tx_ready", {31'h0, s_tx_ready}, 32'h1);
        chk("async_rst_cfg_done", {31'h0, cfg_done}, 32'h0);

        // Arbitration after reset: TX first, then strict alternation
        stall_cfg = 0; status = 32'h0; m_rx_ready = 1'b1;
        s_tx_data = 8'h10; s_tx_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("uncfg_tx_load", {31'h0, s_tx_ready}, 32'h0);
        n0 = log_n;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_log(n0 + 10, "arb_wait");
        chk_entry(n0, "arb_baud", 3'd1, 1'b1, 32'h01230456, 4'hF);
        chk_entry(n0 + 1, "arb_ctrl", 3'd0, 1'b1, 32'h00000B00, 4'h2);
        for (int i = 0; i < 2; i++) begin
            chk_entry(n0 + 2 + 4*i, "arb_poll_a", 3'd0, 1'b0, 32'h0, 4'h0);
            chk_entry(n0 + 3 + 4*i, "arb_tx", 3'd4, 1'b1, 32'h00000010, 4'h1);
            chk_entry(n0 + 4 + 4*i, "arb_poll_b", 3'd0, 1'b0, 32'h0, 4'h0);
            chk_entry(n0 + 5 + 4*i, "arb_rx", 3'd5, 1'b0, 32'h0, 4'h0);
        end

        // Reconfiguration requested during a stalled TX write
        stall_cfg = 5;
        wait_bus(1'b1, 3'd4, "stalled_tx_seen");
        n0 = log_n;
        cfg_baud_freq = 12'hABC; cfg_baud_limit = 16'h1234;
        cfg_pbit = 1'b0; cfg_ptype = 1'b0; cfg_sbit = 2'b01;
        s_tx_valid = 1'b0; status = 32'h1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("reconf_done_fall", {31'h0, cfg_done}, 32'h0);
        wait_log(n0 + 3, "reconf_baud");
        chk("reconf_done_low", {31'h0, cfg_done}, 32'h0);
        wait_log(n0 + 4, "reconf_ctrl");
        chk_entry(n0, "reconf_tx", 3'd4, 1'b1, 32'h00000010, 4'h1);
        chk_entry(n0 + 1, "reconf_poll", 3'd0, 1'b0, 32'h0, 4'h0);
        chk_entry(n0 + 2, "reconf_baud", 3'd1, 1'b1, 32'h0ABC1234, 4'hF);
        chk_entry(n0 + 3, "reconf_ctrl", 3'd0, 1'b1, 32'h00000400, 4'h2);
        chk("reconf_done_rise", {31'h0, cfg_done}, 32'h1);
        chk("bus_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
